fifo_flex: RTL
==============

Name: fifo_flex

Overview:
- Parametrised synchronous single-clock FIFO; next-generation buffer for datapath stages between producer and consumer blocks.
- Supports any depth (not only powers of two) and true full capacity of FIFO_DEPTH entries.
- Selectable read mode (registered or first-word-fall-through), occupancy count, programmable almost-full/almost-empty, sticky overflow/underflow error flags.

Parameters:
- DATA_WIDTH, 32, width of data word (>=1)
- FIFO_DEPTH, 8, number of storage entries (>=2, any integer)
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through
- AFULL_THRESH, FIFO_DEPTH-1, o_almost_full asserted when count >= this value
- AEMPTY_THRESH, 1, o_almost_empty asserted when count <= this value
- CNT_W, $clog2(FIFO_DEPTH+1), width of o_count (derived, not overridden)

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  reset, synchronous, active-low
- i_write  input  1  write request
- i_data  input  DATA_WIDTH  write data
- i_read  input  1  read request
- o_data  output  DATA_WIDTH  read data
- o_valid  output  1  o_data qualifier
- o_full  output  1  count == FIFO_DEPTH
- o_empty  output  1  count == 0
- o_almost_full  output  1  count >= AFULL_THRESH
- o_almost_empty  output  1  count <= AEMPTY_THRESH
- o_count  output  CNT_W  current occupancy
- i_clr_err  input  1  clears sticky error flags
- o_overflow  output  1  sticky: write attempted while full
- o_underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset and clock: reset i_rst_n, synchronous, active-low; clock i_clk.
- Reset values:
  - wr_ptr = rd_ptr = 0, count = 0.
  - o_empty = 1, o_full = 0, o_almost_empty = 1, o_almost_full = 0.
  - o_overflow = o_underflow = 0.
  - FWFT=0: o_data = 0, o_valid = 0.
  - Storage array is not reset.
- Reset mid-operation: all contents discarded; state identical to power-on reset on the next cycle.
- Accept rules:
  - wr_acc = i_write & ~o_full.
  - rd_acc = i_read & ~o_empty.
  - Both evaluated from registered state at the start of the cycle.
- Full with simultaneous read and write: read accepted, write dropped (counts as overflow); count decrements by 1.
- Empty with simultaneous read and write: write accepted, read rejected (counts as underflow); no bypass.
- Both accepted: count unchanged; both pointers advance.
- Pointers: range 0..FIFO_DEPTH-1; explicit wrap from FIFO_DEPTH-1 to 0 (no power-of-two modulo).
- Counter: count += wr_acc - rd_acc, never outside 0..FIFO_DEPTH.
- Status flags: all combinational from registered count only; no dependence on same-cycle i_read/i_write.
- Read mode FWFT=0:
  - On rd_acc, o_data <= mem[rd_ptr]; o_valid = 1 in the following cycle only.
  - o_data holds its value when there is no rd_acc.
  - Latency from i_read to data is 1 cycle.
- Read mode FWFT=1:
  - o_data = mem[rd_ptr] combinationally; o_valid = ~o_empty.
  - i_read pops the head; the next word is visible in the same cycle the pointer advances.
  - A write into an empty FIFO is visible at o_data one cycle after wr_acc.
- Errors:
  - o_overflow sets on i_write & o_full; o_underflow sets on i_read & o_empty.
  - i_clr_err clears both. If a set and a clear occur in the same cycle, the set wins.
- Elaboration checks: FIFO_DEPTH < 2, AFULL_THRESH > FIFO_DEPTH, or AEMPTY_THRESH >= FIFO_DEPTH raises an elaboration-time $error.

Decomposition:
- Package fifo_pkg:
  - function cnt_width(depth) returning $clog2(depth+1).
  - localparam enum for read mode: FIFO_MODE_STD = 0, FIFO_MODE_FWFT = 1.
- Sub-module fifo_ram:
  - Simple dual-port storage (DATA_WIDTH x FIFO_DEPTH).
  - Write port: synchronous write enable.
  - Read port: asynchronous read address.
  - fifo_flex holds pointers, count, flags and the output register.

Test Plan:
- DEPTH=5, FWFT=0: write 0x11..0x15 in 5 cycles. Result: o_full=1 after 5th write, o_count=5. 6th write 0x16 dropped, o_overflow=1. Read 5 words returns 0x11..0x15, each one cycle after i_read; o_empty=1 at end.
- DEPTH=5 wrap-around: write/read 12 words streaming (both asserted each cycle after first write). Data order preserved across pointer wrap 4->0; o_count stays 1.
- Full with simultaneous read and write: i_read=i_write=1, i_data=0xAA. Head is read, 0xAA never appears, o_count 5->4, o_overflow=1.
- FWFT=1, DEPTH=8: single write 0x5A into empty FIFO. Next cycle o_valid=1, o_data=0x5A with no read. Pulse i_read: o_valid=0 the following cycle.
- AFULL_THRESH=6, AEMPTY_THRESH=2, DEPTH=8: fill one word per cycle.
  - o_almost_empty=1 at counts 0..2, 0 at 3.
  - o_almost_full=1 from count 6.
  - Read while empty sets o_underflow. i_clr_err with a simultaneous empty read keeps o_underflow=1; clear on the next cycle gives 0.
- Reset mid-operation: with 3 words stored, assert i_rst_n=0 for 1 cycle. Next cycle o_count=0, o_empty=1, error flags 0. A subsequent write/read returns only the new data.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the fifo_flex buffer family.
package fifo_pkg;

  typedef enum logic {
    FIFO_MODE_STD  = 1'b0,
    FIFO_MODE_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write port, asynchronous read port.
module fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_flex.sv
// Single-clock FIFO of arbitrary depth with registered or fall-through read,
// occupancy count, programmable almost flags and sticky error flags.
module fifo_flex
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 8,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 1,
  parameter int AEMPTY_THRESH = 1,
  parameter int CNT_W         = cnt_width(FIFO_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_write,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_read,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic [CNT_W-1:0]      o_count,
  input  logic                  i_clr_err,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam fifo_mode_e READ_MODE = (FWFT != 0) ? FIFO_MODE_FWFT : FIFO_MODE_STD;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AEMPTY_THRESH);

  if (FIFO_DEPTH < 2) begin : g_err_depth
    $error("fifo_flex: FIFO_DEPTH must be at least 2");
  end
  if (AFULL_THRESH > FIFO_DEPTH) begin : g_err_afull
    $error("fifo_flex: AFULL_THRESH exceeds FIFO_DEPTH");
  end
  if (AEMPTY_THRESH >= FIFO_DEPTH) begin : g_err_aempty
    $error("fifo_flex: AEMPTY_THRESH must be below FIFO_DEPTH");
  end
  if (CNT_W != cnt_width(FIFO_DEPTH)) begin : g_err_cntw
    $error("fifo_flex: CNT_W is derived from FIFO_DEPTH and must not be overridden");
  end

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] head_data;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign o_count        = count;
  assign o_full         = (count == FULL_CNT);
  assign o_empty        = (count == '0);
  assign o_almost_full  = (count >= AF_CNT);
  assign o_almost_empty = (count <= AE_CNT);

  assign wr_acc = i_write & ~o_full;
  assign rd_acc = i_read & ~o_empty;

  fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .ADDR_W    (PTR_W)
  ) u_ram (
    .i_clk  (i_clk),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr),
    .wr_data(i_data),
    .rd_addr(rd_ptr),
    .rd_data(head_data)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (rd_acc) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (wr_acc && !rd_acc) begin
        count <= count + CNT_W'(1);
      end else if (rd_acc && !wr_acc) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // A new error event in the same cycle as a clear keeps the flag set.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      o_overflow  <= (i_write & o_full) | (o_overflow & ~i_clr_err);
      o_underflow <= (i_read & o_empty) | (o_underflow & ~i_clr_err);
    end
  end

  if (READ_MODE == FIFO_MODE_FWFT) begin : g_fwft
    assign o_data  = head_data;
    assign o_valid = ~o_empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) begin
          data_q <= head_data;
        end
      end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
  end

endmodule
